pipelined_right_shifter_with_sticky: RTL and testbench
======================================================

Name: pipelined_right_shifter_with_sticky

Overview:
Parameterized, fully pipelined logarithmic right shifter with a variable shift amount. It supports logical and arithmetic modes and produces a sticky bit, which is the OR of all bits shifted out. It is the sequential, variable-amount counterpart of the fixed left-shift blocks in the arithmetic chapter. It is intended for FP mantissa alignment and similar datapaths. It accepts one operation per cycle, with valid-only flow control and no backpressure.

Parameters:
- N, default 8: data width. Must be a power of two, N >= 4.
- LOG2N, default $clog2(N): number of pipeline stages, and therefore the latency in cycles.
- SW, default $clog2(N)+1: width of the shift-amount input, so that the value N is representable.

Ports:
- clk, input, 1: clock. All state changes on its rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- arg_vld, input, 1: input operation valid this cycle.
- a, input, N: operand.
- shift, input, SW: shift amount, unsigned, 0..2^SW-1.
- arith, input, 1: 1 = arithmetic (fill with a[N-1]); 0 = logical (fill with 0).
- res_vld, output, 1: result valid. Asserted exactly LOG2N cycles after the matching arg_vld.
- res, output, N: shifted result.
- sticky, output, 1: OR of every bit of a that was shifted out.

Behaviour:
- Reset: synchronous, active-low (rst_n sampled low at a rising clk edge).
  - All pipeline registers clear: every stage valid = 0, data = 0, sticky = 0, fill bit = 0.
  - Outputs after reset: res_vld = 0, res = 0, sticky = 0.
- Pipeline structure:
  - LOG2N stages. Stage k (k = 0..LOG2N-1) conditionally shifts right by 2^k when shift[k] = 1.
  - Each stage carries forward: valid, data, the fill bit, the remaining shift bits, and the accumulated sticky.
- Stage 0 input pre-processing (combinational, before the stage-0 register):
  - fill = arith & a[N-1].
  - sat = (shift >= N).
  - If sat: stage-0 data = {N{fill}}, sticky = |a, and all later stages are forced to pass the data through unchanged.
- Stage k shift rules, when shift[k] = 1 and not sat:
  - data_next = {{2^k{fill}}, data[N-1:2^k]}.
  - sticky_next = sticky | (|data[2^k-1:0]).
  - When shift[k] = 0, data and sticky pass through unchanged.
- Register update rules:
  - A stage's data and sticky registers load only when the upstream valid = 1; otherwise they hold.
  - Valid registers load every cycle.
  - Consequence: res and sticky hold the last result while res_vld = 0.
- Latency and throughput:
  - Latency is exactly LOG2N cycles: arg_vld high at edge t gives res_vld high after edge t+LOG2N.
  - Throughput is 1 per cycle. Back-to-back inputs yield back-to-back outputs in order, with no interaction between them.
  - Bubbles (arg_vld = 0) propagate as res_vld = 0 in the same relative slot.
- Boundary cases:
  - shift = 0: res = a, sticky = 0.
  - shift = N-1, logical: res = {{N-1{0}}, a[N-1]}.
  - shift >= N, including 2^SW-1: saturated result as defined above; sticky = |a.
  - a = 0: res = 0, sticky = 0 for any shift and mode.
- Reset mid-operation: all in-flight operations are discarded. res_vld stays 0 from the cycle after the reset edge until new inputs traverse the full pipeline.
- Mixed modes: arith is captured per operation; consecutive operations in different modes do not interact.
- No combinational path from inputs to outputs. All outputs come directly from final-stage registers.

Test Plan:
- N=8, a=8'b1011_0100, shift=3, arith=0 -> after 3 cycles: res_vld=1, res=8'b0001_0110, sticky=1.
- Same a and shift, arith=1 -> res=8'b1111_0110, sticky=1. Then shift=2, arith=0 -> res=8'b0010_1101, sticky=0. Then shift=0 -> res=8'b1011_0100, sticky=0.
- Saturation: a=8'b1000_0001 with shift=8, then shift=15.
  - arith=0 -> res=8'h00, sticky=1.
  - arith=1 -> res=8'hFF, sticky=1.
  - Repeat with a=0 -> res=0, sticky=0.
- Throughput: 16 back-to-back random operations, then an arg_vld pattern 1,0,1,1,0.
  - Each result matches a software model: (arith ? $signed(a)>>>s : a>>s), saturating for s >= 8.
  - res_vld reproduces the input pattern delayed by exactly 3 cycles.
- Reset: drive 3 valid operations, then assert rst_n=0 for 1 cycle while they are in flight.
  - Next cycle: res_vld=0, res=0, sticky=0.
  - No stale result appears afterwards.
  - The first new operation emerges exactly 3 cycles after it is presented.
- Hold: after one valid operation followed by idle cycles, res and sticky remain stable while res_vld=0.

Source files
------------

// File: rtl/pipelined_right_shifter_with_sticky.sv
//------------------------------------------------------------------------------
// pipelined_right_shifter_with_sticky
//
// Fully pipelined logarithmic right shifter with a variable shift amount.
// It supports logical and arithmetic fill. The sticky output is the OR of
// every operand bit shifted out past the LSB, which is what FP mantissa
// alignment needs for rounding.
//
// Pipeline organisation
//   - Stage k (k = 0 .. LOG2N-1) shifts right by 2^k when its shift bit is
//     set, then registers the result.
//   - The latency is therefore LOG2N cycles, and the block accepts one new
//     operation every cycle.
//   - Flow control is valid-only, with no backpressure.
//   - Each stage carries forward:
//       * valid
//       * data
//       * the accumulated sticky
//       * the fill bit
//       * the shift bits still to be applied
//   - Data and sticky registers load only when the upstream valid is high.
//     The outputs therefore hold the last result while res_vld is low.
//
// Saturation (shift >= N)
//   - The front end replaces the operand with all-fill.
//   - It seeds sticky with |a.
//   - It zeroes the remaining shift bits, so every stage passes the word
//     through unchanged.
//
// Parameters
//   N      data width, a power of two, N >= 4
//   LOG2N  number of stages (= latency), must equal $clog2(N)
//   SW     shift-amount width, at least LOG2N+1 so that N is representable
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset; clears every pipeline register
//   arg_vld  operation valid this cycle
//   a        operand
//   shift    unsigned shift amount, 0 .. 2^SW-1
//   arith    1 = arithmetic (fill with a[N-1]), 0 = logical (fill with 0)
//   res_vld  result valid, LOG2N cycles after the matching arg_vld
//   res      shifted result (registered)
//   sticky   OR of all bits of a shifted out (registered)
//------------------------------------------------------------------------------
module pipelined_right_shifter_with_sticky #(
    parameter int N     = 8,
    parameter int LOG2N = $clog2(N),
    parameter int SW    = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arg_vld,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] shift,
    input  logic          arith,
    output logic          res_vld,
    output logic [N-1:0]  res,
    output logic          sticky
);

    // Reject parameter sets the stage structure cannot support.
    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("pipelined_right_shifter_with_sticky: N must be a power of two >= 4");
    end
    if (LOG2N != $clog2(N)) begin : g_bad_log2n
        $error("pipelined_right_shifter_with_sticky: LOG2N must equal $clog2(N)");
    end
    if (SW < LOG2N + 1) begin : g_bad_sw
        $error("pipelined_right_shifter_with_sticky: SW must be at least LOG2N+1");
    end

    //--------------------------------------------------------------------------
    // Front end: fill bit, saturation detect and operand substitution.
    // Saturation zeroes the per-stage shift bits, so later stages need no
    // separate saturation flag.
    //--------------------------------------------------------------------------
    logic             fill_in;
    logic             sat_in;
    logic [N-1:0]     data_in;
    logic             stk_in;
    logic [LOG2N-1:0] sh_in;

    assign fill_in = arith & a[N-1];
    assign sat_in  = (shift >= SW'(N));
    assign data_in = sat_in ? {N{fill_in}} : a;
    assign stk_in  = sat_in & (|a);
    assign sh_in   = sat_in ? '0 : shift[LOG2N-1:0];

    //--------------------------------------------------------------------------
    // Shift stages.
    //
    // Per-stage signals:
    //   *_i  the stage's inputs
    //   *_d  the stage's combinational result
    //   *_q  the stage's output register
    //
    // For k > 0, the fill bit and the remaining shift bits arrive through
    // registers kept in block k. Those registers load in step with stage k-1's
    // data. The shift vector narrows by one bit per stage: stage k consumes
    // bit 0 and hands the rest on.
    //--------------------------------------------------------------------------
    for (genvar k = 0; k < LOG2N; k++) begin : g_stage
        localparam int D = 1 << k;

        logic               vld_i;
        logic [N-1:0]       data_i;
        logic               stk_i;
        logic               fill_i;
        logic [LOG2N-1-k:0] sh_i;

        logic [N-1:0]       data_d;
        logic               stk_d;

        logic               vld_q;
        logic [N-1:0]       data_q;
        logic               stk_q;

        if (k == 0) begin : g_first
            assign vld_i  = arg_vld;
            assign data_i = data_in;
            assign stk_i  = stk_in;
            assign fill_i = fill_in;
            assign sh_i   = sh_in;
        end else begin : g_rest
            logic               fill_r;
            logic [LOG2N-1-k:0] sh_r;

            // These registers sit alongside stage k-1's data register and share
            // its load enable, so all of them describe the same operation.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    fill_r <= 1'b0;
                    sh_r   <= '0;
                end else if (g_stage[k-1].vld_i) begin
                    fill_r <= g_stage[k-1].fill_i;
                    sh_r   <= g_stage[k-1].sh_i[LOG2N-k:1];
                end
            end

            assign vld_i  = g_stage[k-1].vld_q;
            assign data_i = g_stage[k-1].data_q;
            assign stk_i  = g_stage[k-1].stk_q;
            assign fill_i = fill_r;
            assign sh_i   = sh_r;
        end

        // Shift by 2^k. The D bits that fall off the bottom fold into sticky.
        assign data_d = sh_i[0] ? {{D{fill_i}}, data_i[N-1:D]} : data_i;
        assign stk_d  = stk_i | (sh_i[0] & (|data_i[D-1:0]));

        // NOTE: sequential state uses non-blocking assignments so that every
        // stage samples its upstream value from before the clock edge. Blocking
        // assignments here would let data race through several stages in one
        // cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                stk_q  <= 1'b0;
            end else begin
                vld_q <= vld_i;
                if (vld_i) begin
                    data_q <= data_d;
                    stk_q  <= stk_d;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs come straight from the final stage registers. There is no
    // combinational path from any input.
    //--------------------------------------------------------------------------
    assign res_vld = g_stage[LOG2N-1].vld_q;
    assign res     = g_stage[LOG2N-1].data_q;
    assign sticky  = g_stage[LOG2N-1].stk_q;

endmodule

// File: tb/tb_pipelined_right_shifter_with_sticky.sv
//------------------------------------------------------------------------------
// Testbench for pipelined_right_shifter_with_sticky (N = 8, latency 3).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so every sample lies well away from the active edge.
//------------------------------------------------------------------------------
module tb_pipelined_right_shifter_with_sticky;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int SW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arg_vld;
    logic [N-1:0]  a;
    logic [SW-1:0] shift;
    logic          arith;
    logic          res_vld;
    logic [N-1:0]  res;
    logic          sticky;

    int checks = 0;
    int errors = 0;

    pipelined_right_shifter_with_sticky #(
        .N     (N),
        .LOG2N (LOG2N),
        .SW    (SW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arg_vld (arg_vld),
        .a       (a),
        .shift   (shift),
        .arith   (arith),
        .res_vld (res_vld),
        .res     (res),
        .sticky  (sticky)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [3:0] sv,
                         input logic arv);
        arg_vld = v;
        a       = av;
        shift   = sv;
        arith   = arv;
    endtask

    // Reference: the shift uses the language operators. Sticky is the OR of
    // the bits below the shift point. Shifts of 8 or more saturate.
    function automatic logic [8:0] model(input logic [7:0] av, input logic [3:0] sv,
                                         input logic arv);
        logic [7:0] r;
        logic       s;
        if (sv >= 4'd8) begin
            r = {8{arv & av[7]}};
            s = |av;
        end else begin
            if (arv) r = $signed(av) >>> sv;
            else     r = av >> sv;
            s = |(av & ((8'd1 << sv) - 8'd1));
        end
        return {s, r};
    endfunction

    //--------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 8'hA5, 4'd1, 1'b1);
        step();
        step();
        step();
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_res_vld: got %b expected 0", res_vld);
        end
        checks++;
        if (res !== 8'h00) begin
            errors++;
            $display("FAIL reset_res: got %h expected 00", res);
        end
        checks++;
        if (sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got %b expected 0", sticky);
        end
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (res_vld !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_vld[%0d]: got %b expected 0", i, res_vld);
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // Directed shifts, including the shift = 0 and shift = N-1 boundaries.
    task automatic test_directed();
        logic [7:0] ta [8] = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'h70, 8'h70};
        logic [3:0] ts [8] = '{4'd3, 4'd3, 4'd2, 4'd0, 4'd7, 4'd7, 4'd4, 4'd0};
        logic       tr [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] er [8] = '{8'h16, 8'hF6, 8'h2D, 8'hB4, 8'h01, 8'hFF, 8'h07, 8'h70};
        logic       es [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ta[i], ts[i], tr[i]);
            step();
            drive(1'b0, 8'h00, 4'd0, 1'b0);
            step();
            checks++;
            if (res_vld !== 1'b0) begin
                errors++;
                $display("FAIL directed_early_vld[%0d]: got %b expected 0", i, res_vld);
            end
            step();
            checks++;
            if (res_vld !== 1'b1) begin
                errors++;
                $display("FAIL directed_vld[%0d]: got %b expected 1", i, res_vld);
            end
            checks++;
            if (res !== er[i]) begin
                errors++;
                $display("FAIL directed_res[%0d]: got %h expected %h", i, res, er[i]);
            end
            checks++;
            if (sticky !== es[i]) begin
                errors++;
                $display("FAIL directed_sticky[%0d]: got %b expected %b", i, sticky, es[i]);
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // Shifts of N and above, including the maximum 15, in both modes and with
    // a zero operand.
    task automatic test_saturation();
        logic [7:0] ta [8] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h00, 8'h00, 8'h00, 8'h7F};
        logic [3:0] ts [8] = '{4'd8, 4'd15, 4'd8, 4'd15, 4'd8, 4'd15, 4'd5, 4'd9};
        logic       tr [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] er [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       es [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ta[i], ts[i], tr[i]);
            step();
            drive(1'b0, 8'h00, 4'd0, 1'b0);
            step();
            step();
            checks++;
            if (res_vld !== 1'b1) begin
                errors++;
                $display("FAIL sat_vld[%0d]: got %b expected 1", i, res_vld);
            end
            checks++;
            if (res !== er[i]) begin
                errors++;
                $display("FAIL sat_res[%0d]: got %h expected %h", i, res, er[i]);
            end
            checks++;
            if (sticky !== es[i]) begin
                errors++;
                $display("FAIL sat_sticky[%0d]: got %b expected %b", i, sticky, es[i]);
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // Sixteen consecutive operations with mixed modes. Each result must appear
    // exactly three cycles after its input, in order.
    task automatic test_back_to_back();
        logic [7:0] ta  [16];
        logic [3:0] ts  [16];
        logic       tr  [16];
        logic [8:0] exp [16];
        for (int i = 0; i < 16; i++) begin
            ta[i]  = 8'($urandom);
            ts[i]  = 4'($urandom_range(0, 15));
            tr[i]  = 1'($urandom_range(0, 1));
        end
        ts[3] = 4'd8;
        ts[7] = 4'd15;
        ta[5] = 8'h00;
        ta[9] = 8'h80;
        tr[9] = 1'b1;
        for (int i = 0; i < 16; i++) exp[i] = model(ta[i], ts[i], tr[i]);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b1, ta[i], ts[i], tr[i]);
            else        drive(1'b0, 8'h00, 4'd0, 1'b0);
            step();
            if (i >= 2) begin
                checks++;
                if (res_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_vld[%0d]: got %b expected 1", i - 2, res_vld);
                end
                checks++;
                if ({sticky, res} !== exp[i-2]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: a=%h s=%0d ar=%b got sticky=%b res=%h expected sticky=%b res=%h",
                             i - 2, ta[i-2], ts[i-2], tr[i-2], sticky, res, exp[i-2][8], exp[i-2][7:0]);
                end
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // Valid pattern 1,0,1,1,0. Bubbles carry junk operands that must not
    // be loaded.
    task automatic test_bubbles();
        logic       pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ta  [5] = '{8'hC3, 8'hFF, 8'h96, 8'h0F, 8'hFF};
        logic [3:0] ts  [5] = '{4'd2, 4'd1, 4'd5, 4'd1, 4'd1};
        logic       tr  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [8:0] exp;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(pat[i], ta[i], ts[i], tr[i]);
            else       drive(1'b0, 8'hFF, 4'd1, 1'b1);
            step();
            if (i >= 2) begin
                checks++;
                if (res_vld !== pat[i-2]) begin
                    errors++;
                    $display("FAIL bubble_vld[%0d]: got %b expected %b", i - 2, res_vld, pat[i-2]);
                end
                if (pat[i-2]) begin
                    exp = model(ta[i-2], ts[i-2], tr[i-2]);
                    checks++;
                    if ({sticky, res} !== exp) begin
                        errors++;
                        $display("FAIL bubble_data[%0d]: got sticky=%b res=%h expected sticky=%b res=%h",
                                 i - 2, sticky, res, exp[8], exp[7:0]);
                    end
                end
            end
        end
    endtask

    //--------------------------------------------------------------------------
    // Reset while three operations are in flight.
    task automatic test_reset_mid();
        drive(1'b1, 8'hB4, 4'd3, 1'b0);
        step();
        drive(1'b1, 8'h81, 4'd8, 1'b1);
        step();
        drive(1'b1, 8'hF0, 4'd1, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL midreset_vld: got %b expected 0", res_vld);
        end
        checks++;
        if (res !== 8'h00) begin
            errors++;
            $display("FAIL midreset_res: got %h expected 00", res);
        end
        checks++;
        if (sticky !== 1'b0) begin
            errors++;
            $display("FAIL midreset_sticky: got %b expected 0", sticky);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (res_vld !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale[%0d]: got %b expected 0", i, res_vld);
            end
        end
        drive(1'b1, 8'hF1, 4'd4, 1'b1);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lat1: got %b expected 0", res_vld);
        end
        step();
        checks++;
        if (res_vld !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lat2: got %b expected 0", res_vld);
        end
        step();
        checks++;
        if (res_vld !== 1'b1 || res !== 8'hFF || sticky !== 1'b1) begin
            errors++;
            $display("FAIL midreset_new: got vld=%b res=%h sticky=%b expected vld=1 res=ff sticky=1",
                     res_vld, res, sticky);
        end
    endtask

    //--------------------------------------------------------------------------
    // Outputs hold while idle, even when the idle inputs change.
    task automatic test_hold();
        drive(1'b1, 8'h6D, 4'd2, 1'b0);
        step();
        drive(1'b0, 8'hFF, 4'd1, 1'b1);
        step();
        step();
        checks++;
        if (res_vld !== 1'b1 || res !== 8'h1B || sticky !== 1'b1) begin
            errors++;
            $display("FAIL hold_first: got vld=%b res=%h sticky=%b expected vld=1 res=1b sticky=1",
                     res_vld, res, sticky);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'(8'h11 * (i + 3)), 4'(i), 1'(i));
            step();
            checks++;
            if (res_vld !== 1'b0 || res !== 8'h1B || sticky !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%b res=%h sticky=%b expected vld=0 res=1b sticky=1",
                         i, res_vld, res, sticky);
            end
        end
    endtask

    //--------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        test_reset();
        test_directed();
        test_saturation();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Runaway guard.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
